serial_frame_rx: RTL

//  Downstream consumer of the 4-stage serial shift chain: takes the chain's serial

---
 rtl/serial_frame_rx.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync-word hunt, MSB-first payload deserialisation,
// even-parity check and a 1-deep valid/ready output buffer.
module serial_frame_rx #(
  parameter int unsigned             DATA_W = 8,
  parameter int unsigned             SYNC_W = 4,
  parameter logic [SYNC_W-1:0]       SYNC   = 4'b1011,
  parameter int unsigned             CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              en,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              par_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    PARITY
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SYNC_W-1:0]   hist;
  logic [SYNC_W-1:0]   hist_next;
  logic [DATA_W-1:0]   sreg;
  logic [DATA_W-1:0]   sreg_next;
  logic [BIT_W-1:0]    cnt;
  logic [BIT_W-1:0]    cnt_next;
  logic [SYNC_W-1:0]   hist_shift;
  logic                parity;
  logic                good;
  logic                bad_par;
  logic                load;

  assign hist_shift = {hist[SYNC_W-2:0], in};
  assign parity     = ^{sreg, in};
  // A good frame only enters the buffer if it is empty or being drained this cycle.
  assign load       = good & (~out_valid | out_ready);

  // Next-state logic; everything holds on cycles without a qualified bit.
  always_comb begin
    state_next = state;
    hist_next  = hist;
    sreg_next  = sreg;
    cnt_next   = cnt;
    good       = 1'b0;
    bad_par    = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          hist_next = hist_shift;
          if (hist_shift == SYNC) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          sreg_next = {sreg[DATA_W-2:0], in};
          cnt_next  = cnt + BIT_W'(1);
          if (cnt == BIT_W'(DATA_W - 1)) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          // History cleared so no sync bits can overlap into the next frame.
          state_next = HUNT;
          hist_next  = '0;
          bad_par    = parity;
          good       = ~parity;
        end
        default: begin
          state_next = HUNT;
          hist_next  = '0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      hist      <= '0;
      sreg      <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state   <= state_next;
      hist    <= hist_next;
      sreg    <= sreg_next;
      cnt     <= cnt_next;
      par_err <= bad_par;
      if (good & out_valid & ~out_ready) begin
        overflow <= 1'b1;
      end
      if (load) begin
        out_data  <= sreg;
        out_valid <= 1'b1;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
